// File: rtl/board_game_fsm_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// board_game_fsm_pkg : shared codes, state encoding and walk directions
// Rev 1.0
// ------------------------------------------------------------------
package board_game_fsm_pkg;

   localparam logic [1:0] MARK_EMPTY  = 2'b00;
   localparam logic [1:0] MARK_PLAYER = 2'b01;
   localparam logic [1:0] MARK_BOT    = 2'b10;

   localparam logic [1:0] WIN_NONE    = 2'b00;
   localparam logic [1:0] WIN_PLAYER  = 2'b01;
   localparam logic [1:0] WIN_BOT     = 2'b10;
   localparam logic [1:0] WIN_TIE     = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_P_WAIT    = 3'd1,
      ST_P_VAL     = 3'd2,
      ST_AI_REQ    = 3'd3,
      ST_AI_WAIT   = 3'd4,
      ST_AI_VAL    = 3'd5,
      ST_CHECK     = 3'd6,
      ST_GAME_OVER = 3'd7
   } state_e;

   typedef struct packed {
      logic signed [1:0] dr;
      logic signed [1:0] dc;
   } step_t;

   // side[2:1] picks the line direction, side[0] walks it backwards
   function automatic step_t side_step(input logic [2:0] side);
      step_t s;
      case (side[2:1])
         2'd0:    s = '{dr: 2'sd0, dc: 2'sd1};
         2'd1:    s = '{dr: 2'sd1, dc: 2'sd0};
         2'd2:    s = '{dr: 2'sd1, dc: 2'sd1};
         default: s = '{dr: 2'sd1, dc: -2'sd1};
      endcase
      if (side[0]) begin
         s.dr = -s.dr;
         s.dc = -s.dc;
      end
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/board_game_fsm_line_walker.sv
`default_nettype none
// ------------------------------------------------------------------
// line_walker : one cell per cycle along both sides of 4 directions
// Rev 1.0
// ------------------------------------------------------------------
module line_walker
   import board_game_fsm_pkg::*;
#(
   parameter  int N     = 3,
   parameter  int K     = 3,
   localparam int CELLS = N * N,
   localparam int IDX_W = $clog2(CELLS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [IDX_W-1:0]     last_idx,
   input  logic [1:0]           mark,
   input  logic [2*CELLS-1:0]   board,
   output logic                 done,
   output logic                 win
);

   localparam int RC_W   = $clog2(N) + 3;
   localparam int DIST_W = $clog2(K + 1);
   localparam int RUN_W  = $clog2(2 * K);
   localparam logic signed [RC_W-1:0] RC_ZERO = '0;
   localparam logic signed [RC_W-1:0] RC_N    = RC_W'(N);

   logic                     active_q, active_d;
   logic [2:0]               side_q, side_d;
   logic [DIST_W-1:0]        dist_q, dist_d;
   logic signed [RC_W-1:0]   r_q, r_d, c_q, c_d;
   logic signed [RC_W-1:0]   r0_q, r0_d, c0_q, c0_d;
   logic                     alive_q, alive_d;
   logic [RUN_W-1:0]         run_q, run_d;
   logic                     win_q, win_d;
   logic [1:0]               mark_q, mark_d;

   logic signed [RC_W-1:0]   org_r, org_c;
   logic                     w_in, w_hit, w_last_side, w_dir_win;
   logic [1:0]               w_cell;
   logic [RUN_W-1:0]         w_run;
   step_t                    st_cur, st_next, st_first;

   always_comb begin
      org_r = '0;
      org_c = '0;
      for (int i = 0; i < CELLS; i++) begin
         if (last_idx == IDX_W'(i)) begin
            org_r = RC_W'(i / N);
            org_c = RC_W'(i % N);
         end
      end
   end

   // bounds are checked on row/col so a side never wraps into the next row
   always_comb begin
      w_in   = (r_q >= RC_ZERO) && (r_q < RC_N) && (c_q >= RC_ZERO) && (c_q < RC_N);
      w_cell = MARK_EMPTY;
      for (int i = 0; i < CELLS; i++) begin
         if (w_in && (r_q == RC_W'(i / N)) && (c_q == RC_W'(i % N)))
            w_cell = board[2*i +: 2];
      end
   end

   always_comb begin
      active_d    = active_q;
      side_d      = side_q;
      dist_d      = dist_q;
      r_d         = r_q;
      c_d         = c_q;
      r0_d        = r0_q;
      c0_d        = c0_q;
      alive_d     = alive_q;
      run_d       = run_q;
      win_d       = win_q;
      mark_d      = mark_q;
      st_cur      = side_step(side_q);
      st_next     = side_step(side_q + 3'd1);
      st_first    = side_step(3'd0);
      w_hit       = active_q && alive_q && w_in && (w_cell == mark_q);
      w_run       = run_q + RUN_W'(w_hit);
      w_last_side = (dist_q == DIST_W'(K - 1));
      w_dir_win   = w_last_side && side_q[0] && (w_run >= RUN_W'(K - 1));

      if (start) begin
         active_d = 1'b1;
         side_d   = 3'd0;
         dist_d   = DIST_W'(1);
         r0_d     = org_r;
         c0_d     = org_c;
         r_d      = org_r + RC_W'(st_first.dr);
         c_d      = org_c + RC_W'(st_first.dc);
         alive_d  = 1'b1;
         run_d    = '0;
         win_d    = 1'b0;
         mark_d   = mark;
      end else if (active_q) begin
         if (w_last_side) begin
            side_d  = side_q + 3'd1;
            dist_d  = DIST_W'(1);
            r_d     = r0_q + RC_W'(st_next.dr);
            c_d     = c0_q + RC_W'(st_next.dc);
            alive_d = 1'b1;
            run_d   = side_q[0] ? '0 : w_run;
            win_d   = win_q | w_dir_win;
            if (side_q == 3'd7)
               active_d = 1'b0;
         end else begin
            dist_d  = dist_q + DIST_W'(1);
            r_d     = r_q + RC_W'(st_cur.dr);
            c_d     = c_q + RC_W'(st_cur.dc);
            alive_d = w_hit;
            run_d   = w_run;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active_q <= 1'b0;
         side_q   <= '0;
         dist_q   <= '0;
         r_q      <= '0;
         c_q      <= '0;
         r0_q     <= '0;
         c0_q     <= '0;
         alive_q  <= 1'b0;
         run_q    <= '0;
         win_q    <= 1'b0;
         mark_q   <= MARK_EMPTY;
      end else begin
         active_q <= active_d;
         side_q   <= side_d;
         dist_q   <= dist_d;
         r_q      <= r_d;
         c_q      <= c_d;
         r0_q     <= r0_d;
         c0_q     <= c0_d;
         alive_q  <= alive_d;
         run_q    <= run_d;
         win_q    <= win_d;
         mark_q   <= mark_d;
      end
   end

   assign done = active_q && (side_q == 3'd7) && w_last_side;
   assign win  = win_q | (done && w_dir_win);

endmodule
`default_nettype wire

// File: rtl/board_game_fsm.sv
`default_nettype none
// ------------------------------------------------------------------
// board_game_fsm : N x N, K-in-a-row flow controller, player vs bot
// Rev 1.0
// ------------------------------------------------------------------
module board_game_fsm
   import board_game_fsm_pkg::*;
#(
   parameter  int N       = 3,
   parameter  int K       = 3,
   parameter  int AI_TOUT = 1024,
   localparam int IDX_W   = $clog2(N * N),
   localparam int CNT_W   = $clog2(N * N + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 first_sel,
   input  logic [IDX_W-1:0]     p_tick,
   input  logic                 p_confirm,
   output logic                 ai_req,
   input  logic [IDX_W-1:0]     ai_tick,
   input  logic                 ai_ack,
   output logic [2*N*N-1:0]     cell_position,
   output logic [1:0]           winner,
   output logic                 player_turn,
   output logic [CNT_W-1:0]     move_cnt,
   output logic                 err_invalid,
   output logic                 ai_timeout
);

   localparam int             CELLS   = N * N;
   localparam int             TOUT_W  = $clog2(AI_TOUT + 1);
   localparam logic [IDX_W:0] CELLS_X = (IDX_W + 1)'(CELLS);

   state_e                 state_q, state_d;
   logic [2*CELLS-1:0]     board_q, board_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [1:0]             winner_q, winner_d;
   logic                   ai_req_q, ai_req_d;
   logic                   err_q, err_d;
   logic                   tout_hit_q, tout_hit_d;
   logic [TOUT_W-1:0]      tout_q, tout_d;
   logic [IDX_W-1:0]       move_idx_q, move_idx_d;
   logic [1:0]             last_mark_q, last_mark_d;

   logic                   walk_start, walk_done, walk_win;
   logic [1:0]             w_cell, w_side_mark;
   logic                   w_move_ok;

   always_comb begin
      w_cell = MARK_EMPTY;
      for (int i = 0; i < CELLS; i++) begin
         if (move_idx_q == IDX_W'(i))
            w_cell = board_q[2*i +: 2];
      end
      w_move_ok   = ({1'b0, move_idx_q} < CELLS_X) && (w_cell == MARK_EMPTY);
      w_side_mark = (state_q == ST_P_VAL) ? MARK_PLAYER : MARK_BOT;
   end

   always_comb begin
      state_d     = state_q;
      board_d     = board_q;
      cnt_d       = cnt_q;
      winner_d    = winner_q;
      ai_req_d    = 1'b0;
      err_d       = 1'b0;
      tout_hit_d  = 1'b0;
      tout_d      = tout_q;
      move_idx_d  = move_idx_q;
      last_mark_d = last_mark_q;
      walk_start  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (first_sel) begin
               state_d = ST_P_WAIT;
            end else begin
               state_d  = ST_AI_REQ;
               ai_req_d = 1'b1;
            end
         end
         ST_P_WAIT: begin
            if (p_confirm) begin
               move_idx_d = p_tick;
               state_d    = ST_P_VAL;
            end
         end
         ST_P_VAL, ST_AI_VAL: begin
            if (w_move_ok) begin
               for (int i = 0; i < CELLS; i++) begin
                  if (move_idx_q == IDX_W'(i))
                     board_d[2*i +: 2] = w_side_mark;
               end
               cnt_d       = cnt_q + CNT_W'(1);
               last_mark_d = w_side_mark;
               walk_start  = 1'b1;
               state_d     = ST_CHECK;
            end else begin
               err_d = 1'b1;
               if (state_q == ST_P_VAL) begin
                  state_d = ST_P_WAIT;
               end else begin
                  state_d  = ST_AI_REQ;
                  ai_req_d = 1'b1;
               end
            end
         end
         ST_AI_REQ: begin
            tout_d  = '0;
            state_d = ST_AI_WAIT;
         end
         // an ack arriving on the expiry cycle is still accepted
         ST_AI_WAIT: begin
            if (ai_ack) begin
               move_idx_d = ai_tick;
               state_d    = ST_AI_VAL;
            end else if (tout_q == TOUT_W'(AI_TOUT - 1)) begin
               tout_hit_d = 1'b1;
               winner_d   = WIN_PLAYER;
               state_d    = ST_GAME_OVER;
            end else begin
               tout_d = tout_q + TOUT_W'(1);
            end
         end
         ST_CHECK: begin
            if (walk_done) begin
               if (walk_win) begin
                  winner_d = last_mark_q;
                  state_d  = ST_GAME_OVER;
               end else if (cnt_q == CNT_W'(CELLS)) begin
                  winner_d = WIN_TIE;
                  state_d  = ST_GAME_OVER;
               end else if (last_mark_q == MARK_PLAYER) begin
                  state_d  = ST_AI_REQ;
                  ai_req_d = 1'b1;
               end else begin
                  state_d = ST_P_WAIT;
               end
            end
         end
         ST_GAME_OVER: begin
            if (p_confirm) begin
               board_d  = '0;
               cnt_d    = '0;
               winner_d = WIN_NONE;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         board_q     <= '0;
         cnt_q       <= '0;
         winner_q    <= WIN_NONE;
         ai_req_q    <= 1'b0;
         err_q       <= 1'b0;
         tout_hit_q  <= 1'b0;
         tout_q      <= '0;
         move_idx_q  <= '0;
         last_mark_q <= MARK_EMPTY;
      end else begin
         state_q     <= state_d;
         board_q     <= board_d;
         cnt_q       <= cnt_d;
         winner_q    <= winner_d;
         ai_req_q    <= ai_req_d;
         err_q       <= err_d;
         tout_hit_q  <= tout_hit_d;
         tout_q      <= tout_d;
         move_idx_q  <= move_idx_d;
         last_mark_q <= last_mark_d;
      end
   end

   line_walker #(
      .N (N),
      .K (K)
   ) u_walker (
      .clk      (clk),
      .rst      (rst),
      .start    (walk_start),
      .last_idx (move_idx_q),
      .mark     (w_side_mark),
      .board    (board_q),
      .done     (walk_done),
      .win      (walk_win)
   );

   assign cell_position = board_q;
   assign winner        = winner_q;
   assign player_turn   = (state_q == ST_P_WAIT);
   assign move_cnt      = cnt_q;
   assign ai_req        = ai_req_q;
   assign err_invalid   = err_q;
   assign ai_timeout    = tout_hit_q;

endmodule
`default_nettype wire

// File: tb/tb_board_game_fsm.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_board_game_fsm : 5x5 / 4-in-a-row bench against a board-scan model
// Rev 1.0
// ------------------------------------------------------------------
module tb_board_game_fsm;

   localparam int N       = 5;
   localparam int K       = 4;
   localparam int TOUT    = 16;
   localparam int CELLS   = N * N;
   localparam int IDX_W   = $clog2(CELLS);
   localparam int CNT_W   = $clog2(CELLS + 1);
   localparam int CHK_LAT = 8 * (K - 1);

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 first_sel;
   logic [IDX_W-1:0]     p_tick;
   logic                 p_confirm;
   logic                 ai_req;
   logic [IDX_W-1:0]     ai_tick;
   logic                 ai_ack;
   logic [2*CELLS-1:0]   cell_position;
   logic [1:0]           winner;
   logic                 player_turn;
   logic [CNT_W-1:0]     move_cnt;
   logic                 err_invalid;
   logic                 ai_timeout;

   board_game_fsm #(
      .N       (N),
      .K       (K),
      .AI_TOUT (TOUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .first_sel     (first_sel),
      .p_tick        (p_tick),
      .p_confirm     (p_confirm),
      .ai_req        (ai_req),
      .ai_tick       (ai_tick),
      .ai_ack        (ai_ack),
      .cell_position (cell_position),
      .winner        (winner),
      .player_turn   (player_turn),
      .move_cnt      (move_cnt),
      .err_invalid   (err_invalid),
      .ai_timeout    (ai_timeout)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   int mb[CELLS];
   int mcnt;
   int mwin;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic model_clear();
      for (int i = 0; i < CELLS; i++) mb[i] = 0;
      mcnt = 0;
      mwin = 0;
   endtask

   function automatic logic [2*CELLS-1:0] exp_board();
      logic [2*CELLS-1:0] b = '0;
      for (int i = 0; i < CELLS; i++) b[2*i +: 2] = 2'(mb[i]);
      return b;
   endfunction

   // full-board scan for any K consecutive equal marks
   function automatic int line_winner();
      int dr[4] = '{0, 1, 1, 1};
      int dc[4] = '{1, 0, 1, -1};
      int m, rr, cc;
      bit ok;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            for (int d = 0; d < 4; d++) begin
               m = mb[r*N + c];
               if (m != 0) begin
                  ok = 1'b1;
                  for (int s = 1; s < K; s++) begin
                     rr = r + s * dr[d];
                     cc = c + s * dc[d];
                     if (rr < 0 || rr >= N || cc < 0 || cc >= N) ok = 1'b0;
                     else if (mb[rr*N + cc] != m) ok = 1'b0;
                  end
                  if (ok) return m;
               end
            end
      return 0;
   endfunction

   function automatic bit move_legal(input int idx);
      if (idx >= CELLS) return 1'b0;
      return mb[idx] == 0;
   endfunction

   task automatic finish_check(input int mover);
      int ew;
      ew = line_winner();
      if (ew == 0 && mcnt == CELLS) ew = 3;
      repeat (CHK_LAT - 1) tick();
      check_eq("pre_verdict_winner", winner, 0);
      tick();
      check_eq("verdict_winner", winner, ew);
      mwin = ew;
      if (ew != 0) begin
         check_eq("over_player_turn", player_turn, 0);
         check_eq("over_ai_req", ai_req, 0);
      end else if (mover == 1) begin
         check_eq("handoff_ai_req", ai_req, 1);
      end else begin
         check_eq("handoff_player_turn", player_turn, 1);
      end
   endtask

   task automatic player_move(input int idx);
      bit v;
      v = move_legal(idx);
      check_eq("p_turn_entry", player_turn, 1);
      p_tick    = IDX_W'(idx);
      p_confirm = 1'b1;
      tick();
      p_confirm = 1'b0;
      tick();
      if (!v) begin
         check_eq("p_err_pulse", err_invalid, 1);
         check_eq("p_err_board", cell_position, exp_board());
         check_eq("p_err_back_wait", player_turn, 1);
         return;
      end
      mb[idx] = 1;
      mcnt++;
      check_eq("p_mark", cell_position, exp_board());
      check_eq("p_cnt", move_cnt, mcnt);
      check_eq("p_no_err", err_invalid, 0);
      finish_check(1);
   endtask

   task automatic bot_move(input int idx, input int delay);
      bit v;
      v = move_legal(idx);
      check_eq("ai_req_entry", ai_req, 1);
      tick();
      repeat (delay) tick();
      ai_tick = IDX_W'(idx);
      ai_ack  = 1'b1;
      tick();
      ai_ack = 1'b0;
      check_eq("ack_no_timeout", ai_timeout, 0);
      tick();
      if (!v) begin
         check_eq("b_err_pulse", err_invalid, 1);
         check_eq("b_err_rereq", ai_req, 1);
         check_eq("b_err_board", cell_position, exp_board());
         return;
      end
      mb[idx] = 2;
      mcnt++;
      check_eq("b_mark", cell_position, exp_board());
      check_eq("b_cnt", move_cnt, mcnt);
      finish_check(2);
   endtask

   task automatic bot_timeout();
      check_eq("ai_req_entry", ai_req, 1);
      repeat (TOUT) tick();
      check_eq("tout_not_yet", ai_timeout, 0);
      check_eq("tout_not_yet_winner", winner, 0);
      tick();
      check_eq("tout_pulse", ai_timeout, 1);
      check_eq("tout_winner", winner, 1);
      tick();
      check_eq("tout_pulse_end", ai_timeout, 0);
      check_eq("tout_winner_hold", winner, 1);
      mwin = 1;
   endtask

   task automatic start_game(input bit pf);
      first_sel = pf;
      tick();
      check_eq("start_player_turn", player_turn, pf);
      check_eq("start_ai_req", ai_req, !pf);
   endtask

   task automatic restart_game(input bit pf);
      p_confirm = 1'b1;
      tick();
      p_confirm = 1'b0;
      check_eq("restart_board", cell_position, 0);
      check_eq("restart_winner", winner, 0);
      check_eq("restart_cnt", move_cnt, 0);
      model_clear();
      start_game(pf);
   endtask

   task automatic random_game(input int first_turn);
      int turn, idx, moves;
      bit v;
      int q[$];
      turn  = first_turn;
      moves = 0;
      while (mwin == 0 && moves < 150) begin
         moves++;
         if ($urandom_range(0, 7) == 0) begin
            idx = $urandom_range(0, 31);
         end else begin
            q.delete();
            for (int i = 0; i < CELLS; i++) if (mb[i] == 0) q.push_back(i);
            idx = q[$urandom_range(0, q.size() - 1)];
         end
         v = move_legal(idx);
         if (turn == 1) player_move(idx);
         else           bot_move(idx, $urandom_range(0, TOUT - 1));
         if (v && mwin == 0) turn = 3 - turn;
      end
      check_eq("game_terminated", mwin != 0, 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int pl[$];
      int bl[$];
      bit pf;

      rst = 1'b1; first_sel = 1'b0; p_confirm = 1'b0; p_tick = '0;
      ai_ack = 1'b0; ai_tick = '0;
      model_clear();
      tick();
      tick();
      check_eq("rst_board", cell_position, 0);
      check_eq("rst_winner", winner, 0);
      check_eq("rst_cnt", move_cnt, 0);
      check_eq("rst_player_turn", player_turn, 0);
      check_eq("rst_ai_req", ai_req, 0);
      check_eq("rst_err", err_invalid, 0);
      check_eq("rst_tout", ai_timeout, 0);

      // bot-first diagonal win; last ack lands on the expiry cycle
      rst = 1'b0;
      start_game(1'b0);
      bot_move(0, 0);
      player_move(3);
      bot_move(6, 3);
      player_move(4);
      bot_move(12, 7);
      player_move(5);
      bot_move(18, TOUT - 1);
      check_eq("diag_cnt", move_cnt, 7);
      ai_ack = 1'b1;
      tick();
      ai_ack = 1'b0;
      tick();
      check_eq("over_hold_winner", winner, 2);
      check_eq("over_hold_board", cell_position, exp_board());

      // index-contiguous 3,4,5,6 spans two rows and must not win
      restart_game(1'b1);
      player_move(3);
      bot_move(10, 1);
      player_move(4);
      bot_move(15, 2);
      player_move(5);
      bot_move(24, 0);
      player_move(3);
      player_move(25);
      player_move(6);
      check_eq("wrap_no_win", winner, 0);
      random_game(2);

      // full board with no line of four
      restart_game(1'b1);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            if (((c + 2 * r) / 2) % 2 == 0) pl.push_back(r * N + c);
            else                            bl.push_back(r * N + c);
      for (int i = 0; i < pl.size(); i++) begin
         player_move(pl[i]);
         if (i < bl.size()) bot_move(bl[i], $urandom_range(0, TOUT - 1));
      end
      check_eq("tie_winner", winner, 3);
      check_eq("tie_cnt", move_cnt, CELLS);

      // rejected bot move re-requests and restarts the timeout
      restart_game(1'b0);
      bot_move(30, 10);
      bot_timeout();

      // reset in the middle of AI_WAIT
      restart_game(1'b1);
      player_move(12);
      tick();
      tick();
      rst = 1'b1;
      tick();
      check_eq("mid_rst_board", cell_position, 0);
      check_eq("mid_rst_winner", winner, 0);
      check_eq("mid_rst_cnt", move_cnt, 0);
      check_eq("mid_rst_ai_req", ai_req, 0);
      check_eq("mid_rst_player_turn", player_turn, 0);
      check_eq("mid_rst_err", err_invalid, 0);
      check_eq("mid_rst_tout", ai_timeout, 0);
      rst = 1'b0;
      model_clear();
      pf = 1'($urandom_range(0, 1));
      start_game(pf);
      random_game(pf ? 1 : 2);

      for (int g = 0; g < 6; g++) begin
         pf = 1'($urandom_range(0, 1));
         restart_game(pf);
         random_game(pf ? 1 : 2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
